fetch_stage: RTL and testbench

//  IF stage of the RV32I 5-stage pipeline: owns PCF, issues instruction-memory requests, and fills the IF/ID register.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/fetch_stage_if_id_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage: datapath width, bubble
// encoding, fetch FSM state encoding and small PC arithmetic helpers.
package rv32i_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0 -- architectural no-op used as the pipeline bubble
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // FETCH : request outstanding at PCF
   // HOLD  : fetched word parked in the skid buffer while decode is stalled
   // DRAIN : redirect arrived before ack; wait out the stale request
   typedef enum logic [1:0] {
      FETCH = 2'b00,
      HOLD  = 2'b01,
      DRAIN = 2'b10
   } fetch_state_e;

   // Redirect targets are forced onto a word boundary; no misalign trap here.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   // Sequential PC increment; wraps silently at the top of the address space.
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush (bubble) > stall (hold) > load.
// A flush replaces only the instruction and valid bit; the PC fields keep
// their previous contents so downstream debug views stay meaningful.
module if_id_reg
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_WORD = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            stall_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            valid_o
);

   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4_q;
   logic            valid_q;

   // IF/ID state update with flush > stall > load priority, async reset to bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= NOP_WORD;
         pc_q       <= 32'h0000_0000;
         pc_plus4_q <= 32'h0000_0000;
         valid_q    <= 1'b0;
      end else if (flush_i) begin
         instr_q    <= NOP_WORD;
         valid_q    <= 1'b0;
      end else if (stall_i) begin
         instr_q    <= instr_q;
         valid_q    <= valid_q;
      end else if (load_i) begin
         instr_q    <= instr_i;
         pc_q       <= pc_i;
         pc_plus4_q <= pc_plus4_i;
         valid_q    <= 1'b1;
      end else begin
         instr_q    <= instr_q;
         valid_q    <= valid_q;
      end
   end

   assign instr_o    = instr_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage. Owns PCF, keeps at most one imem request
// in flight, parks a fetched word in a skid buffer while decode stalls, and
// drains a stale request before honouring an early redirect from EX.
module fetch_stage
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_WORD     = NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_d_i,
   input  logic            flush_d_i,
   input  logic            pc_src_e_i,
   input  logic [XLEN-1:0] pc_target_e_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] instr_d_o,
   output logic [XLEN-1:0] pc_d_o,
   output logic [XLEN-1:0] pc_plus4_d_o,
   output logic            valid_d_o
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pcf_q;
   logic [XLEN-1:0] redir_pc_q;
   logic [XLEN-1:0] skid_instr_q;
   logic [XLEN-1:0] skid_pc_q;

   logic [XLEN-1:0] target_aligned_s;

   logic            ifid_load_d;
   logic [XLEN-1:0] ifid_instr_d;
   logic [XLEN-1:0] ifid_pc_d;
   logic [XLEN-1:0] ifid_pc_plus4_d;

   assign target_aligned_s = align_word(pc_target_e_i);

   // Request is a pure function of state; suppressed while reset is held
   always_comb begin
      imem_req_o = 1'b0;
      if (rst) begin
         imem_req_o = 1'b0;
      end else begin
         case (state_q)
            FETCH:   imem_req_o = 1'b1;
            DRAIN:   imem_req_o = 1'b1;
            HOLD:    imem_req_o = 1'b0;
            default: imem_req_o = 1'b0;
         endcase
      end
   end

   // PCF is only updated on ack or from HOLD, so in DRAIN it still holds the
   // address of the stale request and the address stays stable until ack
   always_comb begin
      imem_addr_o = pcf_q;
   end

   // Select what (if anything) the IF/ID register loads this cycle
   always_comb begin
      ifid_load_d  = 1'b0;
      ifid_instr_d = skid_instr_q;
      ifid_pc_d    = skid_pc_q;
      case (state_q)
         FETCH: begin
            if (imem_ack_i && !pc_src_e_i && !stall_d_i) begin
               ifid_load_d  = 1'b1;
               ifid_instr_d = imem_rdata_i;
               ifid_pc_d    = pcf_q;
            end else begin
               ifid_load_d  = 1'b0;
            end
         end
         HOLD: begin
            if (!pc_src_e_i && !stall_d_i) begin
               ifid_load_d  = 1'b1;
            end else begin
               ifid_load_d  = 1'b0;
            end
         end
         DRAIN: begin
            ifid_load_d = 1'b0;
         end
         default: begin
            ifid_load_d = 1'b0;
         end
      endcase
      ifid_pc_plus4_d = pc_plus4(ifid_pc_d);
   end

   // Fetch FSM together with PCF, redirect latch and skid buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH;
         pcf_q        <= RESET_VECTOR;
         redir_pc_q   <= RESET_VECTOR;
         skid_instr_q <= NOP_WORD;
         skid_pc_q    <= RESET_VECTOR;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack_i && pc_src_e_i) begin
                  // returned word is on the wrong path: drop it
                  pcf_q   <= target_aligned_s;
                  state_q <= FETCH;
               end else if (imem_ack_i && !stall_d_i) begin
                  pcf_q   <= pc_plus4(pcf_q);
                  state_q <= FETCH;
               end else if (imem_ack_i) begin
                  // decode is stalled: park the word, PCF stays on it
                  skid_instr_q <= imem_rdata_i;
                  skid_pc_q    <= pcf_q;
                  state_q      <= HOLD;
               end else if (pc_src_e_i) begin
                  // request cannot be withdrawn; remember where to go next
                  redir_pc_q <= target_aligned_s;
                  state_q    <= DRAIN;
               end else begin
                  state_q <= FETCH;
               end
            end
            DRAIN: begin
               if (imem_ack_i) begin
                  // a redirect arriving with the ack is the newest one
                  if (pc_src_e_i) begin
                     pcf_q <= target_aligned_s;
                  end else begin
                     pcf_q <= redir_pc_q;
                  end
                  state_q <= FETCH;
               end else if (pc_src_e_i) begin
                  redir_pc_q <= target_aligned_s;
                  state_q    <= DRAIN;
               end else begin
                  state_q <= DRAIN;
               end
            end
            HOLD: begin
               if (pc_src_e_i) begin
                  pcf_q   <= target_aligned_s;
                  state_q <= FETCH;
               end else if (!stall_d_i) begin
                  pcf_q   <= pc_plus4(pcf_q);
                  state_q <= FETCH;
               end else begin
                  state_q <= HOLD;
               end
            end
            default: begin
               state_q <= FETCH;
               pcf_q   <= RESET_VECTOR;
            end
         endcase
      end
   end

   if_id_reg #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_d_i),
      .stall_i    (stall_d_i),
      .load_i     (ifid_load_d),
      .instr_i    (ifid_instr_d),
      .pc_i       (ifid_pc_d),
      .pc_plus4_i (ifid_pc_plus4_d),
      .instr_o    (instr_d_o),
      .pc_o       (pc_d_o),
      .pc_plus4_o (pc_plus4_d_o),
      .valid_o    (valid_d_o)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, delayed ack with
// redirect, redirect+flush, PC wrap (second instance) and async reset.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        pcsrc;
   logic [31:0] target;
   logic        ack;

   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic [31:0] instr;
   logic [31:0] pcd;
   logic [31:0] pc4d;
   logic        valid;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic [31:0] w_instr;
   logic [31:0] w_pcd;
   logic [31:0] w_pc4d;
   logic        w_valid;

   int n_vec;
   int n_bad;

   // instruction memory contents: tagged copy of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign rdata   = mem_word(addr);
   assign w_rdata = mem_word(w_addr);

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall_d_i     (stall),
      .flush_d_i     (flush),
      .pc_src_e_i    (pcsrc),
      .pc_target_e_i (target),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_ack_i    (ack),
      .imem_rdata_i  (rdata),
      .instr_d_o     (instr),
      .pc_d_o        (pcd),
      .pc_plus4_d_o  (pc4d),
      .valid_d_o     (valid)
   );

   fetch_stage #(
      .RESET_VECTOR (32'hFFFF_FFFC)
   ) dut_w (
      .clk           (clk),
      .rst           (rst),
      .stall_d_i     (stall),
      .flush_d_i     (flush),
      .pc_src_e_i    (pcsrc),
      .pc_target_e_i (target),
      .imem_req_o    (w_req),
      .imem_addr_o   (w_addr),
      .imem_ack_i    (ack),
      .imem_rdata_i  (w_rdata),
      .instr_d_o     (w_instr),
      .pc_d_o        (w_pcd),
      .pc_plus4_d_o  (w_pc4d),
      .valid_d_o     (w_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec  = 0;
      n_bad  = 0;
      rst    = 1'b1;
      stall  = 1'b0;
      flush  = 1'b0;
      pcsrc  = 1'b0;
      target = 32'h0000_0000;
      ack    = 1'b0;
      step();
      step();

      // reset state
      chk("rst_req",   {31'd0, req},   32'd0);
      chk("rst_instr", instr,          32'h0000_0013);
      chk("rst_pcd",   pcd,            32'h0000_0000);
      chk("rst_pc4d",  pc4d,           32'h0000_0000);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_addr",  addr,           32'h0000_0000);
      chk("rst_waddr", w_addr,         32'hFFFF_FFFC);

      // 1: streaming, one instruction per cycle
      rst = 1'b0;
      ack = 1'b1;
      #1;
      chk("s1_req0",  {31'd0, req}, 32'd1);
      chk("s1_addr0", addr,         32'h0000_0000);
      step();
      chk("s1_instr0", instr,          32'hC0DE_0000);
      chk("s1_pcd0",   pcd,            32'h0000_0000);
      chk("s1_pc4d0",  pc4d,           32'h0000_0004);
      chk("s1_valid0", {31'd0, valid}, 32'd1);
      chk("s1_addr1",  addr,           32'h0000_0004);
      step();
      chk("s1_instr1", instr, 32'hC0DE_0004);
      chk("s1_pcd1",   pcd,   32'h0000_0004);
      step();
      chk("s1_instr2", instr, 32'hC0DE_0008);
      chk("s1_pcd2",   pcd,   32'h0000_0008);
      chk("s1_addr3",  addr,  32'h0000_000C);

      // 2: stall for three cycles while the word at 0xC is acked
      stall = 1'b1;
      step();
      chk("s2_req_a",   {31'd0, req}, 32'd0);
      chk("s2_pcd_a",   pcd,          32'h0000_0008);
      chk("s2_instr_a", instr,        32'hC0DE_0008);
      step();
      chk("s2_req_b",   {31'd0, req}, 32'd0);
      chk("s2_pcd_b",   pcd,          32'h0000_0008);
      step();
      chk("s2_req_c",   {31'd0, req}, 32'd0);
      chk("s2_instr_c", instr,        32'hC0DE_0008);
      stall = 1'b0;
      step();
      chk("s2_skid_instr", instr, 32'hC0DE_000C);
      chk("s2_skid_pcd",   pcd,   32'h0000_000C);
      chk("s2_req_back",   {31'd0, req}, 32'd1);
      chk("s2_addr_next",  addr,  32'h0000_0010);
      step();
      chk("s2_after_pcd",   pcd,   32'h0000_0010);
      chk("s2_after_instr", instr, 32'hC0DE_0010);

      // 3: delayed ack, redirect to 0x100 while the request to 0x14 is open
      ack = 1'b0;
      step();
      chk("s3_addr_w1", addr, 32'h0000_0014);
      chk("s3_pcd_w1",  pcd,  32'h0000_0010);
      pcsrc  = 1'b1;
      target = 32'h0000_0100;
      step();
      pcsrc  = 1'b0;
      chk("s3_addr_w2", addr,         32'h0000_0014);
      chk("s3_req_w2",  {31'd0, req}, 32'd1);
      chk("s3_pcd_w2",  pcd,          32'h0000_0010);
      step();
      chk("s3_addr_w3", addr, 32'h0000_0014);
      step();
      chk("s3_addr_w4", addr, 32'h0000_0014);
      ack = 1'b1;
      step();
      chk("s3_drop_pcd", pcd,  32'h0000_0010);
      chk("s3_new_addr", addr, 32'h0000_0100);
      step();
      chk("s3_tgt_instr", instr, 32'hC0DE_0100);
      chk("s3_tgt_pcd",   pcd,   32'h0000_0100);

      // 4: redirect + flush with ack; misaligned target 0x103 -> 0x100
      pcsrc  = 1'b1;
      flush  = 1'b1;
      target = 32'h0000_0103;
      step();
      pcsrc = 1'b0;
      flush = 1'b0;
      chk("s4_valid", {31'd0, valid}, 32'd0);
      chk("s4_instr", instr,          32'h0000_0013);
      chk("s4_pcd",   pcd,            32'h0000_0100);
      chk("s4_pc4d",  pc4d,           32'h0000_0104);
      chk("s4_addr",  addr,           32'h0000_0100);
      step();
      chk("s4_refetch_instr", instr,          32'hC0DE_0100);
      chk("s4_refetch_valid", {31'd0, valid}, 32'd1);

      // flush alone: bubble in IF/ID, PCF still advances
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid", {31'd0, valid}, 32'd0);
      chk("fl_pcd",   pcd,            32'h0000_0100);
      chk("fl_addr",  addr,           32'h0000_0108);

      // 6: async reset asserted mid-HOLD
      stall = 1'b1;
      step();
      chk("s6_hold_req", {31'd0, req}, 32'd0);
      rst = 1'b1;
      #1;
      chk("s6_rst_instr", instr,          32'h0000_0013);
      chk("s6_rst_valid", {31'd0, valid}, 32'd0);
      chk("s6_rst_pcd",   pcd,            32'h0000_0000);
      chk("s6_rst_addr",  addr,           32'h0000_0000);
      chk("s6_rst_req",   {31'd0, req},   32'd0);
      stall = 1'b0;
      step();
      rst = 1'b0;
      #1;
      chk("s6_first_req",  {31'd0, req}, 32'd1);
      chk("s6_first_addr", addr,         32'h0000_0000);

      // 5: wrap-around from RESET_VECTOR 0xFFFFFFFC
      chk("s5_waddr0", w_addr, 32'hFFFF_FFFC);
      step();
      chk("s5_wpcd0",  w_pcd,   32'hFFFF_FFFC);
      chk("s5_wpc4d0", w_pc4d,  32'h0000_0000);
      chk("s5_winstr", w_instr, 32'hC0DE_FFFC);
      chk("s5_waddr1", w_addr,  32'h0000_0000);
      chk("s6_pcd0",   pcd,     32'h0000_0000);
      step();
      chk("s5_wpcd1",  w_pcd,  32'h0000_0000);
      chk("s5_wpc4d1", w_pc4d, 32'h0000_0004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
